// File: rtl/muxn_pipe.sv
// N-way WIDTH-bit selector with a registered valid/ready output stage and flush.
// Define MUXN_PIPE_SKID_EN to add a skid register (capacity 2, registered in_ready).
module muxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel
);

`ifdef MUXN_PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
`else
  typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] main_data;
  logic [SEL_W-1:0] main_sel;
  logic             accept, deliver;
  logic             load_main;
`ifdef MUXN_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             load_skid, skid_to_main;
  logic             in_ready_q;
`endif

  // Unmatched select values (in_sel >= N) capture all zeros.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) cap_data = in_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef MUXN_PIPE_SKID_EN
  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;
  assign out_data = main_data;
  assign out_sel  = main_sel;

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
`ifdef MUXN_PIPE_SKID_EN
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
`endif
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (accept && deliver) load_main = 1'b1;
`ifdef MUXN_PIPE_SKID_EN
        else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end
`endif
        else if (deliver) state_nxt = EMPTY;
      end
`ifdef MUXN_PIPE_SKID_EN
      FULL: if (deliver) begin
        state_nxt    = ONE;
        skid_to_main = 1'b1;
      end
`endif
      default: state_nxt = EMPTY;
    endcase
    // Flush drops everything held and any beat offered this cycle.
    if (flush) begin
      state_nxt    = EMPTY;
      load_main    = 1'b0;
`ifdef MUXN_PIPE_SKID_EN
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      main_data  <= '0;
      main_sel   <= '0;
`ifdef MUXN_PIPE_SKID_EN
      skid_data  <= '0;
      skid_sel   <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      if (load_main) begin
        main_data <= cap_data;
        main_sel  <= in_sel;
      end
`ifdef MUXN_PIPE_SKID_EN
      else if (skid_to_main) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end
      if (load_skid) begin
        skid_data <= cap_data;
        skid_sel  <= in_sel;
      end
      in_ready_q <= (state_nxt != FULL);
`endif
    end
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed bench for muxn_pipe: reset, select, out-of-range, back-pressure, flush, throughput.
module tb_muxn_pipe;
  logic         clk = 1'b0;
  logic         rst;
  logic         flush;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   in_sel, out_sel;
  logic [127:0] in_data;
  logic [31:0]  out_data;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]   b_in_sel, b_out_sel;
  logic [95:0]  b_in_data;
  logic [31:0]  b_out_data;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] CH4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  muxn_pipe #(.WIDTH(32), .N(4), .SEL_W(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  muxn_pipe #(.WIDTH(32), .N(3), .SEL_W(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data), .flush(flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_sel(b_out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [31:0] v);
    in_data = {96'h0, v};
    in_sel  = 2'd0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_sel = 2'd0; in_data = CH4;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_sel = 2'd0;
    b_in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();

    // basic select on 4-way, in-range select on 3-way
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_sel = 2'd1; b_out_ready = 1'b1;
    tick();
    check("sel2_valid", 64'(out_valid), 64'd1);
    check("sel2_data", 64'(out_data), 64'h33333333);
    check("sel2_sel", 64'(out_sel), 64'd2);
    check("n3_sel1_data", 64'(b_out_data), 64'h22222222);
    in_valid = 1'b0;
    b_in_sel = 2'd3;
    tick();
    check("sel2_retired", 64'(out_valid), 64'd0);
    check("n3_oor_valid", 64'(b_out_valid), 64'd1);
    check("n3_oor_data", 64'(b_out_data), 64'h0);
    check("n3_oor_sel", 64'(b_out_sel), 64'd3);
    b_in_valid = 1'b0;
    tick();

    // asynchronous reset mid-cycle while holding a beat
    in_valid = 1'b1; in_sel = 2'd1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("pre_rst_data", 64'(out_data), 64'h22222222);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_sel", 64'(out_sel), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // back-pressure: A,B,C on channel 0 with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; beat0(32'h1);
    tick();
`ifdef MUXN_PIPE_SKID_EN
    check("bp_a_in_ready", 64'(in_ready), 64'd1);
    beat0(32'h2);
    tick();
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_head_a", 64'(out_data), 64'h1);
    beat0(32'h3);
    tick();
    check("bp_hold_a", 64'(out_data), 64'h1);
    out_ready = 1'b1;
    tick();
    check("bp_out_b", 64'(out_data), 64'h2);
    tick();
    in_valid = 1'b0;
    check("bp_out_c", 64'(out_data), 64'h3);
`else
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_head_a", 64'(out_data), 64'h1);
    beat0(32'h2);
    tick();
    check("bp_hold_a", 64'(out_data), 64'h1);
    out_ready = 1'b1;
    tick();
    check("bp_out_b", 64'(out_data), 64'h2);
    beat0(32'h3);
    tick();
    in_valid = 1'b0;
    check("bp_out_c", 64'(out_data), 64'h3);
`endif
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // flush with a beat offered the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; beat0(32'hA);
    tick();
`ifdef MUXN_PIPE_SKID_EN
    beat0(32'hB);
    tick();
    check("fl_full", 64'(in_ready), 64'd0);
`else
    out_ready = 1'b1;
`endif
    beat0(32'hD); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("fl_d_dropped", 64'(out_valid), 64'd0);

    // throughput: 16 beats back to back
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat0(32'(i));
      tick();
      check("tp_valid", 64'(out_valid), 64'd1);
      check("tp_data", 64'(out_data), 64'(i));
      check("tp_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("tp_drained", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
